// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: OFF / ON / BLINK / PWM / BREATHE per channel,
// all channels sharing one free-running PWM counter.
module led_pattern_gen #(
  parameter int NUM_CH      = 8,
  parameter int PWM_BITS    = 8,
  parameter int DIV_BITS    = 25,
  parameter int RESET_BLINK = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [2:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  input  logic [DIV_BITS-1:0] cfg_half_period,
  output logic [NUM_CH-1:0]   led
);

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_BLINK   = 3'd2;
  localparam logic [2:0] MODE_PWM     = 3'd3;
  localparam logic [2:0] MODE_BREATHE = 3'd4;

  localparam logic [PWM_BITS-1:0] LEVEL_MAX = {PWM_BITS{1'b1}};
  localparam logic [DIV_BITS-1:0] BLINK_HP  = DIV_BITS'(1) << (DIV_BITS - 1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [2:0]          mode_r        [NUM_CH];
  logic [PWM_BITS-1:0] duty_r        [NUM_CH];
  logic [DIV_BITS-1:0] half_period_r [NUM_CH];
  logic [DIV_BITS-1:0] div_cnt_r     [NUM_CH];
  logic [NUM_CH-1:0]   phase_r;
  logic [PWM_BITS-1:0] level_r       [NUM_CH];
  logic [NUM_CH-1:0]   dir_r;

  logic [NUM_CH-1:0]   wr_hit_s;
  logic [NUM_CH-1:0]   ticking_s;
  logic [NUM_CH-1:0]   step_s;
  logic [DIV_BITS-1:0] term_s        [NUM_CH];
  logic [DIV_BITS-1:0] div_nxt_s     [NUM_CH];
  logic [NUM_CH-1:0]   phase_nxt_s;
  logic [PWM_BITS-1:0] level_nxt_s   [NUM_CH];
  logic [NUM_CH-1:0]   dir_nxt_s;
  logic [NUM_CH-1:0]   led_nxt_s;

  // Per-channel pattern advance and LED decode from the current (pre-edge) state
  always_comb begin
    wr_hit_s    = {NUM_CH{1'b0}};
    ticking_s   = {NUM_CH{1'b0}};
    step_s      = {NUM_CH{1'b0}};
    phase_nxt_s = phase_r;
    dir_nxt_s   = dir_r;
    led_nxt_s   = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit_s[i]  = cfg_we && (int'(cfg_ch) < NUM_CH) && (int'(cfg_ch) == i);
      ticking_s[i] = (mode_r[i] == MODE_BLINK) || (mode_r[i] == MODE_BREATHE);
      // half_period 0 and 1 both mean a step every cycle
      if (half_period_r[i] == {DIV_BITS{1'b0}}) begin
        term_s[i] = {DIV_BITS{1'b0}};
      end else begin
        term_s[i] = half_period_r[i] - DIV_BITS'(1);
      end
      step_s[i] = ticking_s[i] && (div_cnt_r[i] >= term_s[i]);

      if (!ticking_s[i]) begin
        div_nxt_s[i] = div_cnt_r[i];
      end else if (step_s[i]) begin
        div_nxt_s[i] = {DIV_BITS{1'b0}};
      end else begin
        div_nxt_s[i] = div_cnt_r[i] + DIV_BITS'(1);
      end

      if ((mode_r[i] == MODE_BLINK) && step_s[i]) begin
        phase_nxt_s[i] = ~phase_r[i];
      end else begin
        phase_nxt_s[i] = phase_r[i];
      end

      level_nxt_s[i] = level_r[i];
      if ((mode_r[i] == MODE_BREATHE) && step_s[i]) begin
        // Triangle ramp: reverse at the ends without overshooting
        if (dir_r[i]) begin
          if (level_r[i] == LEVEL_MAX) begin
            level_nxt_s[i] = LEVEL_MAX - PWM_BITS'(1);
            dir_nxt_s[i]   = 1'b0;
          end else begin
            level_nxt_s[i] = level_r[i] + PWM_BITS'(1);
            dir_nxt_s[i]   = 1'b1;
          end
        end else begin
          if (level_r[i] == {PWM_BITS{1'b0}}) begin
            level_nxt_s[i] = PWM_BITS'(1);
            dir_nxt_s[i]   = 1'b1;
          end else begin
            level_nxt_s[i] = level_r[i] - PWM_BITS'(1);
            dir_nxt_s[i]   = 1'b0;
          end
        end
      end else begin
        level_nxt_s[i] = level_r[i];
        dir_nxt_s[i]   = dir_r[i];
      end

      case (mode_r[i])
        MODE_OFF:     led_nxt_s[i] = 1'b0;
        MODE_ON:      led_nxt_s[i] = 1'b1;
        MODE_BLINK:   led_nxt_s[i] = phase_r[i];
        MODE_PWM:     led_nxt_s[i] = (pwm_cnt_r < duty_r[i]);
        MODE_BREATHE: led_nxt_s[i] = (pwm_cnt_r < level_r[i]);
        default:      led_nxt_s[i] = 1'b0;
      endcase
    end
  end

  // Channel state, shared PWM counter and registered LED outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pwm_cnt_r <= {PWM_BITS{1'b0}};
      led       <= {NUM_CH{1'b0}};
      phase_r   <= {NUM_CH{1'b0}};
      dir_r     <= {NUM_CH{1'b1}};
      for (int i = 0; i < NUM_CH; i++) begin
        mode_r[i]        <= ((RESET_BLINK != 0) && (i == 0)) ? MODE_BLINK : MODE_OFF;
        half_period_r[i] <= ((RESET_BLINK != 0) && (i == 0)) ? BLINK_HP : {DIV_BITS{1'b0}};
        duty_r[i]        <= {PWM_BITS{1'b0}};
        div_cnt_r[i]     <= {DIV_BITS{1'b0}};
        level_r[i]       <= {PWM_BITS{1'b0}};
      end
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      led       <= led_nxt_s;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit_s[i]) begin
          mode_r[i]        <= cfg_mode;
          duty_r[i]        <= cfg_duty;
          half_period_r[i] <= cfg_half_period;
          div_cnt_r[i]     <= {DIV_BITS{1'b0}};
          phase_r[i]       <= 1'b0;
          level_r[i]       <= {PWM_BITS{1'b0}};
          dir_r[i]         <= 1'b1;
        end else begin
          div_cnt_r[i] <= div_nxt_s[i];
          phase_r[i]   <= phase_nxt_s[i];
          level_r[i]   <= level_nxt_s[i];
          dir_r[i]     <= dir_nxt_s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: a table of channel configurations plus
// hand-written reset/breathe/out-of-range sequences, checked through an edge-ordered scoreboard.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_;
  logic       a_we, b_we;
  logic [2:0] a_ch, b_ch, a_mode, b_mode;
  logic [7:0] a_duty;
  logic [3:0] b_duty, a_hp, b_hp;
  logic [7:0] a_led;
  logic [4:0] b_led;

  always #5 clk = ~clk;

  led_pattern_gen #(.NUM_CH(8), .PWM_BITS(8), .DIV_BITS(4), .RESET_BLINK(1)) dut_a (
    .clk(clk), .rst_(rst_), .cfg_we(a_we), .cfg_ch(a_ch), .cfg_mode(a_mode),
    .cfg_duty(a_duty), .cfg_half_period(a_hp), .led(a_led));

  led_pattern_gen #(.NUM_CH(5), .PWM_BITS(4), .DIV_BITS(4), .RESET_BLINK(0)) dut_b (
    .clk(clk), .rst_(rst_), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_mode(b_mode),
    .cfg_duty(b_duty), .cfg_half_period(b_hp), .led(b_led));

  typedef struct { int edge_n; int dut; int ch; logic exp; } sb_t;
  typedef struct { int ch; int mode; int duty; int hp; int cycles; int exp_high; } vec_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  logic mon_act;
  int   checks = 0;
  int   errors = 0;
  int   ecnt;

  // Rising edges since the last reset release; pwm_cnt before edge k is (k-1) mod 2^PWM_BITS
  always @(posedge clk or negedge rst_) begin
    if (!rst_) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  function automatic void sb_push(int edge_n, int dut, int ch, logic exp);
    sb_t e;
    int  idx;
    e.edge_n = edge_n; e.dut = dut; e.ch = ch; e.exp = exp;
    idx = sb_q.size();
    while (idx > 0 && sb_q[idx-1].edge_n > edge_n) idx--;
    sb_q.insert(idx, e);
  endfunction

  function automatic logic exp_blink(int k, int wr, int hp);
    int hpe;
    hpe = (hp < 1) ? 1 : hp;
    return (((k - wr - 1) / hpe) % 2) == 1;
  endfunction

  function automatic logic exp_pwm(int k, int duty, int bits);
    return ((k - 1) % (1 << bits)) < duty;
  endfunction

  function automatic int tri_level(int j);
    int t;
    t = j % 30;
    return (t <= 15) ? t : 30 - t;
  endfunction

  function automatic logic exp_breathe(int k, int wr);
    return ((k - 1) % 16) < tri_level(k - 1 - wr);
  endfunction

  function automatic logic exp_a(int k, int wr, int mode, int duty, int hp);
    case (mode)
      1:       return 1'b1;
      2:       return exp_blink(k, wr, hp);
      3:       return exp_pwm(k, duty, 8);
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard monitor: compare every expectation due at this edge, away from the rising edge
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].edge_n <= ecnt) begin
      mon_e   = sb_q.pop_front();
      mon_act = (mon_e.dut == 0) ? a_led[3'(mon_e.ch)] : b_led[3'(mon_e.ch)];
      checks++;
      if (mon_e.edge_n != ecnt || mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL led dut%0d ch%0d edge %0d (now %0d): got %b expected %b",
                 mon_e.dut, mon_e.ch, mon_e.edge_n, ecnt, mon_act, mon_e.exp);
      end
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic write_a(input int ch, input int mode, input int duty, input int hp, output int wr);
    @(negedge clk);
    a_we = 1'b1; a_ch = 3'(ch); a_mode = 3'(mode); a_duty = 8'(duty); a_hp = 4'(hp);
    wr = ecnt + 1;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  task automatic write_b(input int ch, input int mode, input int duty, input int hp, output int wr);
    @(negedge clk);
    b_we = 1'b1; b_ch = 3'(ch); b_mode = 3'(mode); b_duty = 4'(duty); b_hp = 4'(hp);
    wr = ecnt + 1;
    @(negedge clk);
    b_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vec [10];
    int   wr_tab [10];
    int   wr, wrb, wr5, wr3, base, highs;

    vec[0] = '{3, 2,   0, 3,  24,  12};
    vec[1] = '{1, 3,  64, 0, 256,  64};
    vec[2] = '{1, 3,   0, 0, 256,   0};
    vec[3] = '{4, 6, 255, 3,  16,   0};
    vec[4] = '{5, 1,   0, 0,  10,  10};
    vec[5] = '{6, 2,   0, 0,  10,   5};
    vec[6] = '{6, 2,   0, 1,  10,   5};
    vec[7] = '{7, 3, 255, 0, 256, 255};
    vec[8] = '{5, 0,   0, 0,  10,   0};
    vec[9] = '{2, 2,   0, 5,  20,  10};

    rst_ = 1'b0;
    a_we = 1'b0; a_ch = 3'd0; a_mode = 3'd0; a_duty = 8'd0; a_hp = 4'd0;
    b_we = 1'b0; b_ch = 3'd0; b_mode = 3'd0; b_duty = 4'd0; b_hp = 4'd0;

    // Reset state, then the power-on blink on channel 0 (half period 8)
    #12;
    check_val("reset_led_a", int'(a_led), 0);
    check_val("reset_led_b", int'(b_led), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_ = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      sb_push(k, 0, 0, exp_blink(k, 0, 8));
      for (int c = 1; c < 8; c++) sb_push(k, 0, c, 1'b0);
      for (int c = 0; c < 5; c++) sb_push(k, 1, c, 1'b0);
    end
    repeat (40) @(negedge clk);

    // Breathe on B ch2, then out-of-range writes that must not alias onto real channels
    write_b(2, 4, 0, 1, wrb);
    for (int k = 1; k <= 64; k++) sb_push(wrb + k, 1, 2, exp_breathe(wrb + k, wrb));
    write_b(7, 1, 0, 0, wr);
    for (int k = 1; k <= 2; k++) begin
      sb_push(wr + k, 1, 3, 1'b0);
      sb_push(wr + k, 1, 1, 1'b0);
    end
    write_b(5, 1, 0, 0, wr5);
    for (int k = 1; k <= 20; k++) begin
      sb_push(wr5 + k, 1, 0, 1'b0);
      sb_push(wr5 + k, 1, 1, 1'b0);
      sb_push(wr5 + k, 1, 4, 1'b0);
    end
    write_b(3, 1, 0, 0, wr3);
    for (int k = 1; k <= 20; k++) sb_push(wr3 + k, 1, 3, 1'b1);
    repeat (70) @(negedge clk);

    // Table-driven configurations on A: per-cycle scoreboard plus high-cycle count
    for (int t = 0; t < 10; t++) begin
      write_a(vec[t].ch, vec[t].mode, vec[t].duty, vec[t].hp, wr);
      wr_tab[t] = wr;
      for (int k = 1; k <= vec[t].cycles; k++)
        sb_push(wr + k, 0, vec[t].ch, exp_a(wr + k, wr, vec[t].mode, vec[t].duty, vec[t].hp));
      highs = 0;
      repeat (vec[t].cycles) begin
        @(negedge clk);
        if (a_led[3'(vec[t].ch)]) highs++;
      end
      check_val($sformatf("high_count vec%0d", t), highs, vec[t].exp_high);
    end

    // Untouched and earlier-written channels kept running through all the writes above
    base = ecnt;
    for (int k = base + 1; k <= base + 32; k++) begin
      sb_push(k, 0, 0, exp_blink(k, 0, 8));
      sb_push(k, 0, 3, exp_blink(k, wr_tab[0], 3));
      sb_push(k, 0, 7, exp_pwm(k, 255, 8));
      sb_push(k, 1, 2, exp_breathe(k, wrb));
      sb_push(k, 1, 3, 1'b1);
    end
    repeat (32) @(negedge clk);

    // Asynchronous reset mid-blink clears outputs at once; pattern restarts on release
    @(posedge clk);
    #3 rst_ = 1'b0;
    #1;
    check_val("async_reset_led_a", int'(a_led), 0);
    check_val("async_reset_led_b", int'(b_led), 0);
    repeat (2) @(negedge clk);
    #3 rst_ = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      sb_push(k, 0, 0, exp_blink(k, 0, 8));
      for (int c = 1; c < 8; c++) sb_push(k, 0, c, 1'b0);
      for (int c = 0; c < 5; c++) sb_push(k, 1, c, 1'b0);
    end
    repeat (26) @(negedge clk);

    check_val("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
